// File: rtl/step_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// step_ctrl
// Button conditioner and run/stop/single-step controller for the LFSR stage.
// It debounces the run and step push-buttons and toggles between free-run and
// hold. In hold, each step press lets the LFSR see exactly one slow_clk rise.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   btn_run    in   raw run/stop button, active-high, asynchronous
//   btn_step   in   raw single-step button, active-high, asynchronous
//   slow_clk   in   divided clock feeding the LFSR (asynchronous level)
//   stp        out  1 = hold LFSR, 0 = LFSR advances on slow_clk rise
//   running    out  1 while in RUN
//   step_done  out  one-clk pulse when a single step completes
//   step_cnt   out  completed single steps, wraps at 256
// -----------------------------------------------------------------------------
module step_ctrl #(
    parameter int DB_COUNT = 1_000_000,
    parameter int DB_W     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       slow_clk,
    output logic       stp,
    output logic       running,
    output logic       step_done,
    output logic [7:0] step_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_STOP = 2'd1,
        ST_ARM  = 2'd2,
        ST_FIRE = 2'd3
    } state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_COUNT - 1);

    // Bit 0 = run button, bit 1 = step button.
    logic [1:0]           btn_sync1_q, btn_sync2_q;
    logic [1:0]           stable_q, stable_d;
    logic [1:0]           stable_dly_q;
    logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]           press_s;

    logic slow_sync1_q, slow_sync2_q, slow_dly_q, slow_rise_q;
    logic slow_rise_d;

    state_t     state_q, state_d;
    logic       stp_q, stp_d;
    logic       running_q, running_d;
    logic       step_done_q, step_done_d;
    logic [7:0] step_cnt_q, step_cnt_d;

    // Debounce: the counter only runs while the synced input disagrees with
    // the accepted value, so any return to agreement restarts the window.
    always_comb begin
        db_cnt_d = db_cnt_q;
        stable_d = stable_q;
        for (int i = 0; i < 2; i++) begin
            if (btn_sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                stable_d[i] = btn_sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
        press_s     = stable_q & ~stable_dly_q;
        // Registered so the FSM reacts three clk after the slow_clk edge.
        slow_rise_d = slow_sync2_q & ~slow_dly_q;
    end

    // Run/stop/step state machine; outputs derive from the next state so
    // they are registered alongside it.
    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        step_done_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (press_s[0]) state_d = ST_STOP;
                else            state_d = ST_RUN;
            end
            ST_STOP: begin
                if (press_s[0])      state_d = ST_RUN;
                else if (press_s[1]) state_d = ST_ARM;
                else                 state_d = ST_STOP;
            end
            // Wait for a rise first, so the enabled window starts cleanly
            // after an edge and the LFSR sees only the following one.
            ST_ARM: begin
                if (press_s[0])       state_d = ST_RUN;
                else if (slow_rise_q) state_d = ST_FIRE;
                else                  state_d = ST_ARM;
            end
            ST_FIRE: begin
                if (press_s[0]) begin
                    state_d = ST_RUN;
                end else if (slow_rise_q) begin
                    state_d     = ST_STOP;
                    step_done_d = 1'b1;
                    step_cnt_d  = step_cnt_q + 8'd1;
                end else begin
                    state_d = ST_FIRE;
                end
            end
            default: state_d = ST_RUN;
        endcase
        stp_d     = (state_d == ST_STOP) || (state_d == ST_ARM);
        running_d = (state_d == ST_RUN);
    end

    // All state: synchronizers, debouncers, edge detectors, FSM and outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_sync1_q  <= 2'b00;
            btn_sync2_q  <= 2'b00;
            stable_q     <= 2'b00;
            stable_dly_q <= 2'b00;
            db_cnt_q     <= '0;
            slow_sync1_q <= 1'b0;
            slow_sync2_q <= 1'b0;
            slow_dly_q   <= 1'b0;
            slow_rise_q  <= 1'b0;
            state_q      <= ST_RUN;
            stp_q        <= 1'b0;
            running_q    <= 1'b1;
            step_done_q  <= 1'b0;
            step_cnt_q   <= 8'd0;
        end else begin
            btn_sync1_q  <= {btn_step, btn_run};
            btn_sync2_q  <= btn_sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            db_cnt_q     <= db_cnt_d;
            slow_sync1_q <= slow_clk;
            slow_sync2_q <= slow_sync1_q;
            slow_dly_q   <= slow_sync2_q;
            slow_rise_q  <= slow_rise_d;
            state_q      <= state_d;
            stp_q        <= stp_d;
            running_q    <= running_d;
            step_done_q  <= step_done_d;
            step_cnt_q   <= step_cnt_d;
        end
    end

    assign stp       = stp_q;
    assign running   = running_q;
    assign step_done = step_done_q;
    assign step_cnt  = step_cnt_q;

endmodule
